mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_controller_op_class_dec.sv | 25 ++
 rtl/mc_controller.sv | 203 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// instruction classes, base opcodes and the pc_sel / wb_sel encodings.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_R      = 3'd0,
      CL_IALU   = 3'd1,
      CL_LOAD   = 3'd2,
      CL_STORE  = 3'd3,
      CL_BRANCH = 3'd4,
      CL_JAL    = 3'd5,
      CL_JALR   = 3'd6,
      CL_ILL    = 3'd7
   } op_class_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SEL_IMM   = 2'd1;
   localparam logic [1:0] PC_SEL_ALU   = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/mc_controller_op_class_dec.sv
// Opcode classifier: maps ir[6:0] onto an instruction class; anything not
// recognised is reported as CL_ILL so the controller can trap on it.
module op_class_dec
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] op_class
);

   // Pure lookup from base opcode to class
   always_comb begin
      op_class = CL_ILL;
      case (opcode)
         OP_R:      op_class = CL_R;
         OP_IALU:   op_class = CL_IALU;
         OP_LOAD:   op_class = CL_LOAD;
         OP_STORE:  op_class = CL_STORE;
         OP_BRANCH: op_class = CL_BRANCH;
         OP_JAL:    op_class = CL_JAL;
         OP_JALR:   op_class = CL_JALR;
         default:   op_class = CL_ILL;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32 control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Strobes are registered from the next state, so no ack input reaches an
// output combinationally. imem_req is the FETCH decode masked by reset.
// Optional feature: define MC_CTRL_INSTRET_EN to add the 32-bit instret
// retired-instruction counter output.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        br_taken,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        alu_src_imm,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        illegal,
`ifdef MC_CTRL_INSTRET_EN
   output logic [31:0] instret,
`endif
   output logic [2:0]  state_o
);

   state_t      state_r, state_next_s;
   logic [31:0] ir_r;
   logic [2:0]  cls_raw_s;
   op_class_t   cls_s;

   logic       pc_we_s, alu_src_imm_s, rf_we_s, retire_s, illegal_s, dmem_req_s, dmem_we_s;
   logic [1:0] pc_sel_s, wb_sel_s;
   logic       pc_we_r, alu_src_imm_r, rf_we_r, retire_r, illegal_r, dmem_req_r, dmem_we_r;
   logic [1:0] pc_sel_r, wb_sel_r;

   op_class_dec u_op_class_dec (
      .opcode   (ir_r[6:0]),
      .op_class (cls_raw_s)
   );

   assign cls_s = op_class_t'(cls_raw_s);

   // State register and instruction latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_FETCH;
         ir_r    <= 32'd0;
      end else begin
         state_r <= state_next_s;
         if (state_r == ST_FETCH && imem_ack) begin
            ir_r <= imem_rdata;
         end
      end
   end

   // Next-state logic; acks only matter in the state that issued the request
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH:  state_next_s = imem_ack ? ST_DECODE : ST_FETCH;
         ST_DECODE: state_next_s = (cls_s == CL_ILL) ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (cls_s)
               CL_BRANCH: state_next_s = ST_FETCH;
               CL_LOAD:   state_next_s = ST_MEM;
               CL_STORE:  state_next_s = ST_MEM;
               default:   state_next_s = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_next_s = (cls_s == CL_STORE) ? ST_FETCH : ST_WB;
            end else begin
               state_next_s = ST_MEM;
            end
         end
         ST_WB:   state_next_s = ST_FETCH;
         ST_TRAP: state_next_s = ST_TRAP;
         default: state_next_s = ST_TRAP;
      endcase
   end

   // Output decode for the state being entered (registered below)
   always_comb begin
      pc_we_s       = 1'b0;
      pc_sel_s      = PC_SEL_PLUS4;
      alu_src_imm_s = 1'b0;
      rf_we_s       = 1'b0;
      wb_sel_s      = WB_SEL_ALU;
      retire_s      = 1'b0;
      illegal_s     = 1'b0;
      dmem_req_s    = 1'b0;
      dmem_we_s     = 1'b0;
      case (state_next_s)
         ST_FETCH: begin
            // Only a completed store leaves MEM straight for FETCH
            if (state_r == ST_MEM) begin
               pc_we_s  = 1'b1;
               retire_s = 1'b1;
            end else begin
               pc_we_s  = 1'b0;
               retire_s = 1'b0;
            end
         end
         ST_EXEC: begin
            alu_src_imm_s = (cls_s != CL_R) && (cls_s != CL_BRANCH);
            if (cls_s == CL_BRANCH) begin
               pc_we_s  = 1'b1;
               retire_s = 1'b1;
            end else begin
               pc_we_s  = 1'b0;
               retire_s = 1'b0;
            end
         end
         ST_MEM: begin
            dmem_req_s = 1'b1;
            dmem_we_s  = (cls_s == CL_STORE);
         end
         ST_WB: begin
            rf_we_s  = 1'b1;
            pc_we_s  = 1'b1;
            retire_s = 1'b1;
            case (cls_s)
               CL_LOAD: wb_sel_s = WB_SEL_MEM;
               CL_JAL:  wb_sel_s = WB_SEL_PC4;
               CL_JALR: wb_sel_s = WB_SEL_PC4;
               default: wb_sel_s = WB_SEL_ALU;
            endcase
            case (cls_s)
               CL_JAL:  pc_sel_s = PC_SEL_IMM;
               CL_JALR: pc_sel_s = PC_SEL_ALU;
               default: pc_sel_s = PC_SEL_PLUS4;
            endcase
         end
         ST_TRAP: illegal_s = 1'b1;
         default: illegal_s = 1'b0;
      endcase
   end

   // Output registers, cleared asynchronously so pending requests drop on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_we_r       <= 1'b0;
         pc_sel_r      <= PC_SEL_PLUS4;
         alu_src_imm_r <= 1'b0;
         rf_we_r       <= 1'b0;
         wb_sel_r      <= WB_SEL_ALU;
         retire_r      <= 1'b0;
         illegal_r     <= 1'b0;
         dmem_req_r    <= 1'b0;
         dmem_we_r     <= 1'b0;
      end else begin
         pc_we_r       <= pc_we_s;
         pc_sel_r      <= pc_sel_s;
         alu_src_imm_r <= alu_src_imm_s;
         rf_we_r       <= rf_we_s;
         wb_sel_r      <= wb_sel_s;
         retire_r      <= retire_s;
         illegal_r     <= illegal_s;
         dmem_req_r    <= dmem_req_s;
         dmem_we_r     <= dmem_we_s;
      end
   end

`ifdef MC_CTRL_INSTRET_EN
   logic [31:0] instret_r;

   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_r <= 32'd0;
      end else if (retire_r) begin
         instret_r <= instret_r + 32'd1;
      end else begin
         instret_r <= instret_r;
      end
   end

   assign instret = instret_r;
`endif

   // Branch target choice follows the live comparator result during EXEC
   assign pc_sel      = (state_r == ST_EXEC && cls_s == CL_BRANCH) ?
                        (br_taken ? PC_SEL_IMM : PC_SEL_PLUS4) : pc_sel_r;
   assign imem_req    = (state_r == ST_FETCH) && !reset;
   assign ir          = ir_r;
   assign dmem_req    = dmem_req_r;
   assign dmem_we     = dmem_we_r;
   assign pc_we       = pc_we_r;
   assign alu_src_imm = alu_src_imm_r;
   assign rf_we       = rf_we_r;
   assign wb_sel      = wb_sel_r;
   assign retire      = retire_r;
   assign illegal     = illegal_r;
   assign state_o     = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes expected retire/trap
// records, a negedge monitor pops and compares when retire or illegal rises.
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] ir;
   logic        dmem_req, dmem_we;
   logic        dmem_ack = 1'b0;
   logic        br_taken = 1'b0;
   logic        pc_we, alu_src_imm, rf_we, retire, illegal;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  state_o;
`ifdef MC_CTRL_INSTRET_EN
   logic [31:0] instret;
`endif

   mc_controller dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .br_taken(br_taken),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
      .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .illegal(illegal),
`ifdef MC_CTRL_INSTRET_EN
      .instret(instret),
`endif
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int kind;      // 0 = retire, 1 = trap entry
      int off;       // cycles from FETCH entry to the retire pulse
      int rf_we;
      int wb_sel;
      int pc_sel;
      int pc_we;
      int fetch_n;
      int dmem_n;
      int dmem_we;
      int alu_imm;
   } exp_t;

   exp_t exp_q[$];
   logic [31:0] prog[$];
   int dmem_delay = 0;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int id, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s (instr %0d): actual=%0d expected=%0d", nm, id, act, expv);
      end
   endtask

   function automatic void push_ret(input int id, input int off, input int rfw, input int wbs,
                                    input int pcs, input int dn, input int dwe, input int ai);
      exp_t e;
      e.id = id; e.kind = 0; e.off = off; e.rf_we = rfw; e.wb_sel = wbs; e.pc_sel = pcs;
      e.pc_we = 1; e.fetch_n = 1; e.dmem_n = dn; e.dmem_we = dwe; e.alu_imm = ai;
      exp_q.push_back(e);
   endfunction

   function automatic void push_trap(input int id);
      exp_t e;
      e = '{id: id, kind: 1, off: 0, rf_we: 0, wb_sel: 0, pc_sel: 0, pc_we: 0,
            fetch_n: 0, dmem_n: 0, dmem_we: 0, alu_imm: 0};
      exp_q.push_back(e);
   endfunction

   // Instruction memory: zero-wait ack while the program queue has words
   always @(negedge clk) begin
      if (imem_req && prog.size() > 0) begin
         imem_ack   = 1'b1;
         imem_rdata = prog.pop_front();
      end else begin
         imem_ack = 1'b0;
      end
   end

   // Data memory: ack after dmem_delay wait cycles
   int wcnt = 0;
   always @(negedge clk) begin
      if (dmem_req) begin
         if (wcnt == dmem_delay) begin
            dmem_ack = 1'b1;
            wcnt = 0;
         end else begin
            dmem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         dmem_ack = 1'b0;
         wcnt = 0;
      end
   end

   // Monitor: per-instruction statistics and scoreboard comparison
   int m_cnt, m_fetch, m_dmem, m_we, m_ai, trap_req;
   logic [2:0] m_prev;
   logic m_prev_ill;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         m_cnt = 0; m_fetch = 0; m_dmem = 0; m_we = 0; m_ai = 0;
         trap_req = 0; m_prev = 3'd7; m_prev_ill = 1'b0;
      end else begin
         if (retire) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_retire", -1, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("kind", e.id, 0, e.kind);
               chk("retire_offset", e.id, m_cnt, e.off);
               chk("rf_we", e.id, rf_we, e.rf_we);
               chk("wb_sel", e.id, wb_sel, e.wb_sel);
               chk("pc_sel", e.id, pc_sel, e.pc_sel);
               chk("pc_we", e.id, pc_we, e.pc_we);
               chk("imem_req_cycles", e.id, m_fetch, e.fetch_n);
               chk("dmem_req_cycles", e.id, m_dmem, e.dmem_n);
               chk("dmem_we", e.id, m_we, e.dmem_we);
               chk("alu_src_imm", e.id, m_ai, e.alu_imm);
            end
         end
         if (illegal && !m_prev_ill) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_trap", -1, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("kind", e.id, 1, e.kind);
               chk("trap_state", e.id, state_o, 5);
               chk("trap_strobes", e.id, {pc_we, rf_we, retire, dmem_req}, 0);
            end
         end
         if (state_o == 3'd5 && imem_req) trap_req++;
         if (state_o == 3'd0 && m_prev != 3'd0) begin
            m_cnt = 0; m_fetch = 0; m_dmem = 0; m_we = 0; m_ai = 0;
         end
         if (imem_req) m_fetch++;
         if (dmem_req) begin
            m_dmem++;
            if (dmem_we) m_we = 1;
         end
         if (state_o == 3'd2) m_ai = alu_src_imm;
         m_cnt++;
         m_prev = state_o;
         m_prev_ill = illegal;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_imem_req", 0, imem_req, 0);
      chk("rst_state", 0, state_o, 0);
      chk("rst_ir", 0, ir, 0);
      chk("rst_strobes", 0, {dmem_req, pc_we, rf_we, retire, illegal}, 0);
      repeat (2) @(posedge clk);
   endtask

   task automatic release_reset();
      #1 reset = 1'b0;
      #1;
      chk("imem_req_after_reset", 0, imem_req, 1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("timeout_pending", 0, exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      // 1: ADDI x1,x0,5
      do_reset(); dmem_delay = 0;
      prog.push_back(32'h00500093); push_ret(1, 3, 1, 0, 0, 0, 0, 1);
      release_reset(); wait_done(30);
      // 2: LW with dmem_ack delayed 3 cycles
      do_reset(); dmem_delay = 3;
      prog.push_back(32'h0000A103); push_ret(2, 7, 1, 1, 0, 4, 0, 1);
      release_reset(); wait_done(30);
      // 3/4: BEQ taken and not taken
      do_reset(); dmem_delay = 0; br_taken = 1'b1;
      prog.push_back(32'h00000463); push_ret(3, 2, 0, 0, 1, 0, 0, 0);
      release_reset(); wait_done(30);
      do_reset(); br_taken = 1'b0;
      prog.push_back(32'h00000463); push_ret(4, 2, 0, 0, 0, 0, 0, 0);
      release_reset(); wait_done(30);
      // 5..8: SW, JAL, JALR, R-type ADD back to back
      do_reset();
      prog.push_back(32'h00112023); push_ret(5, 4, 0, 0, 0, 1, 1, 1);
      prog.push_back(32'h0000006F); push_ret(6, 3, 1, 2, 1, 0, 0, 1);
      prog.push_back(32'h00008067); push_ret(7, 3, 1, 2, 2, 0, 0, 1);
      prog.push_back(32'h002081B3); push_ret(8, 3, 1, 0, 0, 0, 0, 0);
      release_reset(); wait_done(60);
      // 9: LUI is not supported -> absorbing TRAP
      do_reset();
      prog.push_back(32'h00000037); push_trap(9);
      prog.push_back(32'h00500093);
      release_reset(); wait_done(30);
      repeat (10) @(negedge clk);
      #1;
      chk("trap_no_imem_req", 9, trap_req, 0);
      chk("trap_illegal", 9, illegal, 1);
      chk("trap_hold_state", 9, state_o, 5);
      prog.delete();
      // 10: reset asserted mid-MEM of SW
      do_reset(); dmem_delay = 20;
      prog.push_back(32'h00112023);
      release_reset();
      for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
      chk("sw_reached_mem", 10, dmem_req, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midmem_dmem_req", 10, dmem_req, 0);
      chk("midmem_no_retire", 10, {retire, pc_we}, 0);
      @(posedge clk);
      release_reset();
      chk("midmem_state_fetch", 10, state_o, 0);
      repeat (5) @(negedge clk);
      // 11: five back-to-back ADDIs
      do_reset(); dmem_delay = 0;
      for (int i = 0; i < 5; i++) begin
         prog.push_back(32'h00500093);
         push_ret(11 + i, 3, 1, 0, 0, 0, 0, 1);
      end
      release_reset(); wait_done(60);
`ifdef MC_CTRL_INSTRET_EN
      @(negedge clk);
      chk("instret", 11, instret, 5);
`endif
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
